ps2_kbd_port: RTL

//   PS/2 keyboard receiver feeding the ps2kb_key[9:0] read port of the MIO bus (address region 0xD).

---
 rtl/ps2_kbd_port_if.sv | 20 ++
 rtl/ps2_kbd_port.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/ps2_kbd_port_if.sv
// PS/2 keyboard port signals: raw PS/2 lines and pop strobe in, key record and sticky flags out.
// master = bus/keyboard side, slave = ps2_kbd_port.
interface ps2_kbd_port_if;
    logic       ps2_clk;
    logic       ps2_data;
    logic       ps2kb_rd;
    logic [9:0] ps2kb_key;
    logic       fifo_overflow;
    logic       frame_err;

    modport master (
        output ps2_clk, ps2_data, ps2kb_rd,
        input  ps2kb_key, fifo_overflow, frame_err
    );

    modport slave (
        input  ps2_clk, ps2_data, ps2kb_rd,
        output ps2kb_key, fifo_overflow, frame_err
    );
endinterface

// File: rtl/ps2_kbd_port.sv
// PS/2 keyboard receiver: deserialises frames, folds F0/E0 prefixes into {brk, code} records, queues them.
// Record visible 2 cycles after the synced STOP edge; a push into a full FIFO with no pop is dropped (sticky overflow).
module ps2_kbd_port #(
    parameter int FIFO_DEPTH  = 8,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 20000
) (
    input  logic           clk,
    input  logic           rst,
    ps2_kbd_port_if.slave  bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT);

    typedef struct packed {
        logic       brk;
        logic [7:0] code;
    } rec_t;

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] dat_sync;
    logic                   clk_prev;
    logic                   clk_s;
    logic                   dat_s;
    logic                   fall;

    state_t        state;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          par;
    logic [TW-1:0] tmo;
    logic          byte_vld;
    logic          frame_err;

    logic          brk_pend;
    logic          rec_vld;
    rec_t          mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          empty;
    logic          full;
    logic          push;
    logic          pop;
    logic          overflow;
    rec_t          head;

    // Reset to 1s so a reset never manufactures a falling edge on an idle bus.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync <= '1;
            dat_sync <= '1;
            clk_prev <= 1'b1;
        end else begin
            clk_sync <= {clk_sync[SYNC_STAGES-2:0], bus.ps2_clk};
            dat_sync <= {dat_sync[SYNC_STAGES-2:0], bus.ps2_data};
            clk_prev <= clk_s;
        end
    end

    assign clk_s = clk_sync[SYNC_STAGES-1];
    assign dat_s = dat_sync[SYNC_STAGES-1];
    assign fall  = clk_prev & ~clk_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shreg     <= '0;
            par       <= 1'b0;
            tmo       <= '0;
            byte_vld  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            byte_vld <= 1'b0;
            if (fall)
                tmo <= '0;
            else if (tmo != TMO_MAX)
                tmo <= tmo + TW'(1);

            if (fall) begin
                case (state)
                    IDLE: begin
                        if (!dat_s) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                    DATA: begin
                        shreg   <= {dat_s, shreg[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7)
                            state <= PARITY;
                    end
                    PARITY: begin
                        par   <= dat_s;
                        state <= STOP;
                    end
                    default: begin
                        state <= IDLE;
                        if (dat_s && (^shreg ^ par))
                            byte_vld <= 1'b1;
                        else
                            frame_err <= 1'b1;
                    end
                endcase
            end else if (state != IDLE && tmo == TMO_MAX) begin
                state     <= IDLE;
                frame_err <= 1'b1;
            end
        end
    end

    // shreg holds the accepted byte in the cycle after STOP; the next frame is many cycles away.
    assign rec_vld = byte_vld && (shreg != 8'hF0) && (shreg != 8'hE0);
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop     = bus.ps2kb_rd && !empty;
    assign push    = rec_vld && (!full || pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            brk_pend <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (byte_vld) begin
                if (shreg == 8'hF0)
                    brk_pend <= 1'b1;
                else if (shreg != 8'hE0)
                    brk_pend <= 1'b0;
            end
            if (push)
                wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)
                rd_ptr <= rd_ptr + (AW+1)'(1);
            if (rec_vld && full && !pop)
                overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr[AW-1:0]] <= '{brk: brk_pend, code: shreg};
    end

    assign head              = mem[rd_ptr[AW-1:0]];
    assign bus.ps2kb_key     = empty ? 10'h000 : {1'b1, head};
    assign bus.fifo_overflow = overflow;
    assign bus.frame_err     = frame_err;
endmodule
